serial_tx_arbiter: RTL and testbench

Round-robin scheduler that shares one parallel-in/serial-out right-shift datapath among up to eight requesters. Each requester presents a W-bit word and a request. The block grants one requester at a time, loads its word, and shifts it out LSB first, paced by an external bit-enable tick. It sits between game-logic producers (board, score, next-piece) and the single serial link to the display/peripheral driver.

---
 rtl/serial_tx_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_serial_tx_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx_arbiter.sv
// -----------------------------------------------------------------------------
// serial_tx_arbiter
//
// Round-robin scheduler sharing one parallel-in / serial-out right-shift
// datapath among up to eight requesters. A granted word is captured, then
// shifted out LSB first, one bit per bit_en tick, followed by one GAP cycle.
//
// Optional feature macro: SER_TX_PARITY_EN
//   defined   -> an even-parity bit (XOR of the captured word) follows the
//                W data bits, so a frame carries W+1 valid bits.
//   undefined -> frames carry exactly W data bits.
//
// All outputs come straight from flops; nothing on req/data reaches
// ser_out or ser_valid without passing through a register first.
// -----------------------------------------------------------------------------
module serial_tx_arbiter #(
    parameter int W = 8,   // word width, 2..32
    parameter int N = 4    // number of requesters, 1..8
) (
    input  logic           clk,
    input  logic           clear_n,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] data,
    input  logic           bit_en,
    output logic [N-1:0]   ack,
    output logic [2:0]     grant_id,
    output logic           busy,
    output logic           ser_out,
    output logic           ser_valid
);

    // Bit counter holds 0..W so the terminal tick can count past W-1.
    localparam int             CW       = $clog2(W) + 1;
    localparam logic [CW-1:0]  LAST_BIT = CW'(W - 1);
    localparam logic [2:0]     LAST_REQ = 3'(N - 1);
    localparam logic [3:0]     N_REQ    = 4'(N);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
`ifdef SER_TX_PARITY_EN
        ST_PAR   = 2'd2,
`endif
        ST_GAP   = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t         r_state;
    logic [2:0]     r_ptr;        // round-robin start point for next search
    logic [CW-1:0]  r_cnt;        // data bits already shifted out
    logic [W-1:0]   r_shift;      // remaining word, bit 0 is on ser_out
`ifdef SER_TX_PARITY_EN
    logic           r_par;        // even parity of the captured word
`endif
    logic [N-1:0]   r_ack;
    logic [2:0]     r_grant;
    logic           r_busy;
    logic           r_ser_out;
    logic           r_ser_valid;

    // -------------------------------------------------------------------------
    // Combinational arbitration signals
    // -------------------------------------------------------------------------
    logic [7:0]     w_req8;       // req zero-extended to the 8-slot maximum
    logic [W-1:0]   w_words [8];  // data split into words, unused slots zero
    logic [3:0]     w_idx;        // candidate index during the search walk
    logic           w_found;
    logic [2:0]     w_win;
    logic [W-1:0]   w_word;
    logic [2:0]     w_next_ptr;
    logic [N-1:0]   w_onehot;

    // Split the packed data bus into one word per requester slot.
    for (genvar g = 0; g < 8; g++) begin : g_words
        if (g < N) begin : g_used
            assign w_words[g] = data[g*W +: W];
        end else begin : g_unused
            assign w_words[g] = '0;
        end
    end

    // Round-robin search: walk ptr, ptr+1, ... modulo N; first asserted req wins.
    always_comb begin
        // NOTE: every variable written here gets a value before any branch;
        // a path that skips an assignment would infer a latch.
        w_req8         = '0;
        w_req8[N-1:0]  = req;
        w_found        = 1'b0;
        w_win          = '0;
        w_idx          = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = {1'b0, r_ptr} + 4'(k);
            if (w_idx >= N_REQ) begin
                w_idx = w_idx - N_REQ;
            end
            if (!w_found && w_req8[w_idx[2:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[2:0];
            end
        end
    end

    // Winner's word, the pointer value after it, and its one-hot ack pattern.
    always_comb begin
        w_word     = w_words[w_win];
        w_next_ptr = (w_win == LAST_REQ) ? 3'd0 : w_win + 3'd1;
        w_onehot   = '0;
        for (int i = 0; i < N; i++) begin
            w_onehot[i] = (w_win == 3'(i));
        end
    end

    // -------------------------------------------------------------------------
    // Frame FSM with registered outputs. ser_out/ser_valid are computed one
    // step ahead so they appear on the edge that enters each state.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_shift     <= '0;
`ifdef SER_TX_PARITY_EN
            r_par       <= 1'b0;
`endif
            r_ack       <= '0;
            r_grant     <= '0;
            r_busy      <= 1'b0;
            r_ser_out   <= 1'b0;
            r_ser_valid <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // right-hand side here sees the values from before this edge.
            r_ack <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_shift     <= w_word;
                        r_cnt       <= '0;
                        r_grant     <= w_win;
                        r_ack       <= w_onehot;
                        r_ptr       <= w_next_ptr;
                        r_busy      <= 1'b1;
                        r_ser_valid <= 1'b1;
                        r_ser_out   <= w_word[0];
`ifdef SER_TX_PARITY_EN
                        r_par       <= ^w_word;
`endif
                        r_state     <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    if (bit_en) begin
                        r_shift <= r_shift >> 1;
                        r_cnt   <= r_cnt + CW'(1);
                        if (r_cnt == LAST_BIT) begin
`ifdef SER_TX_PARITY_EN
                            r_ser_out   <= r_par;
                            r_state     <= ST_PAR;
`else
                            r_ser_out   <= 1'b0;
                            r_ser_valid <= 1'b0;
                            r_state     <= ST_GAP;
`endif
                        end else begin
                            r_ser_out <= r_shift[1];
                        end
                    end
                end

`ifdef SER_TX_PARITY_EN
                ST_PAR: begin
                    if (bit_en) begin
                        r_ser_out   <= 1'b0;
                        r_ser_valid <= 1'b0;
                        r_state     <= ST_GAP;
                    end
                end
`endif

                ST_GAP: begin
                    // Exactly one idle-line cycle, independent of bit_en.
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack       = r_ack;
    assign grant_id  = r_grant;
    assign busy      = r_busy;
    assign ser_out   = r_ser_out;
    assign ser_valid = r_ser_valid;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for serial_tx_arbiter (W=8, N=4).
// A frame-level model predicts every output each cycle; directed scenarios
// add hand-computed expectations on bit streams, grant order and timing.
// Define SER_TX_PARITY_EN for both bench and design to cover the parity build.
// -----------------------------------------------------------------------------
module tb_serial_tx_arbiter;

    localparam int W = 8;
    localparam int N = 4;
`ifdef SER_TX_PARITY_EN
    localparam int FB = W + 1;
`else
    localparam int FB = W;
`endif
    localparam int PAR_BITS = FB - W;

    logic           clk;
    logic           clear_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] data;
    logic           bit_en;
    logic [N-1:0]   ack;
    logic [2:0]     grant_id;
    logic           busy;
    logic           ser_out;
    logic           ser_valid;

    serial_tx_arbiter #(.W(W), .N(N)) dut (
        .clk       (clk),
        .clear_n   (clear_n),
        .req       (req),
        .data      (data),
        .bit_en    (bit_en),
        .ack       (ack),
        .grant_id  (grant_id),
        .busy      (busy),
        .ser_out   (ser_out),
        .ser_valid (ser_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: actual=0x%0h expected=0x%0h", name, $time, act, exp);
        end
    endtask

    // -------------------------------------------------------------------------
    // Frame-level model: a frame is "active with m_sent bits delivered",
    // then one gap cycle, then idle.
    // -------------------------------------------------------------------------
    logic         m_active;
    logic         m_gap;
    logic         m_ack;
    int           m_sent;
    int           m_id;
    int           m_ptr;
    logic [W-1:0] m_word;

    task automatic model_reset();
        m_active = 1'b0;
        m_gap    = 1'b0;
        m_ack    = 1'b0;
        m_sent   = 0;
        m_id     = 0;
        m_ptr    = 0;
        m_word   = '0;
    endtask

    task automatic model_step();
        int win;
        int c;
        win   = -1;
        m_ack = 1'b0;
        if (m_gap) begin
            m_gap = 1'b0;
        end else if (m_active) begin
            if (bit_en) begin
                m_sent++;
                if (m_sent == FB) begin
                    m_active = 1'b0;
                    m_gap    = 1'b1;
                end
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (win < 0 && req[c]) win = c;
            end
            if (win >= 0) begin
                m_word   = data[win*W +: W];
                m_id     = win;
                m_ptr    = (win + 1) % N;
                m_active = 1'b1;
                m_sent   = 0;
                m_ack    = 1'b1;
            end
        end
    endtask

    always @(posedge clk or negedge clear_n) begin
        if (!clear_n) model_reset();
        else          model_step();
    end

    function automatic logic exp_ser_out();
        if (!m_active)  return 1'b0;
        if (m_sent < W) return m_word[m_sent];
        return ^m_word;
    endfunction

    // Per-cycle comparison against the model, away from the active edge.
    logic           cmp_en = 1'b0;
    logic [N-1:0]   e_ack;
    always @(negedge clk) begin
        if (cmp_en) begin
            e_ack = '0;
            if (m_ack) e_ack[m_id] = 1'b1;
            check("cyc_ack",       ack,       e_ack);
            check("cyc_grant_id",  grant_id,  m_id);
            check("cyc_busy",      busy,      m_active | m_gap);
            check("cyc_ser_valid", ser_valid, m_active);
            check("cyc_ser_out",   ser_out,   exp_ser_out());
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers (all state below is owned by the stimulus process)
    // -------------------------------------------------------------------------
    int          cycle = 0;
    int          rec_n;
    logic [31:0] rec_vec;
    int          hi_cnt;
    int          gap_cnt;

    task automatic rec_clear();
        rec_n   = 0;
        rec_vec = '0;
        hi_cnt  = 0;
        gap_cnt = 0;
    endtask

    // Advance one clock and record what the serial line did in the new cycle.
    task automatic cyc();
        @(negedge clk);
        #1;
        cycle++;
        if (ser_valid) begin
            if (rec_n < 32) rec_vec[rec_n] = ser_out;
            rec_n++;
            if (ser_out) hi_cnt++;
        end
        if (busy && !ser_valid) gap_cnt++;
    endtask

    task automatic set_word(input int i, input logic [W-1:0] w);
        data[i*W +: W] = w;
    endtask

    task automatic do_reset();
        clear_n = 1'b0;
        req     = '0;
        bit_en  = 1'b1;
        cyc();
        clear_n = 1'b1;
        cyc();
        rec_clear();
    endtask

    task automatic wait_ack(output int idx);
        idx = -1;
        for (int k = 0; k < 50 && idx < 0; k++) begin
            cyc();
            for (int i = 0; i < N; i++) if (ack[i]) idx = i;
        end
        check("wait_ack_seen", (idx >= 0), 1);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 200 && busy; k++) cyc();
        check("wait_idle_done", busy, 0);
    endtask

    // -------------------------------------------------------------------------
    // Directed scenarios
    // -------------------------------------------------------------------------
    int idx;
    int prev_cyc;
    int ph;

    initial begin
        clear_n = 1'b1;
        req     = '0;
        data    = '0;
        bit_en  = 1'b1;
        rec_clear();
        #1 clear_n = 1'b0;
        #2;
        check("reset_ack",       ack,       0);
        check("reset_busy",      busy,      0);
        check("reset_ser_valid", ser_valid, 0);
        check("reset_ser_out",   ser_out,   0);
        check("reset_grant_id",  grant_id,  0);
        cmp_en = 1'b1;
        cyc();
        clear_n = 1'b1;
        cyc();

        // 1) Single request on requester 1, word 8'hB0, bit_en tied high.
        do_reset();
        set_word(1, 8'hB0);
        req = 4'b0010;
        wait_ack(idx);
        check("t1_ack_id",   idx,      1);
        check("t1_ack_bits", ack,      4'b0010);
        check("t1_grant_id", grant_id, 1);
        req = '0;
        wait_idle();
        check("t1_valid_bits", rec_n,        FB);
        check("t1_word",       rec_vec[7:0], 8'hB0);
        check("t1_gap_cycles", gap_cnt,      1);

        // 2) req[0] and req[2] together; then req[0]+req[3] shows ptr at 3.
        do_reset();
        set_word(0, 8'h11);
        set_word(2, 8'h22);
        set_word(3, 8'h33);
        req = 4'b0101;
        wait_ack(idx);
        check("t2_first", idx, 0);
        req = 4'b0100;
        wait_ack(idx);
        check("t2_second", idx, 2);
        req = 4'b1001;
        wait_ack(idx);
        check("t2_ptr_at_3", idx, 3);
        req = '0;
        wait_idle();

        // 3) All four held for 8 frames: strict rotation, W+2(+1) spacing.
        do_reset();
        for (int i = 0; i < N; i++) set_word(i, W'(8'h40 + i));
        req = '1;
        prev_cyc = 0;
        for (int f = 0; f < 8; f++) begin
            wait_ack(idx);
            check("t3_order",  idx, f % N);
            check("t3_onehot", $countones(ack), 1);
            if (f > 0) check("t3_interval", cycle - prev_cyc, FB + 2);
            prev_cyc = cycle;
        end
        req = '0;
        wait_idle();

        // 4) bit_en every third cycle, word 8'h01: each bit held 3 cycles.
        do_reset();
        set_word(0, 8'h01);
        bit_en = 1'b0;
        req    = 4'b0001;
        wait_ack(idx);
        check("t4_ack_id", idx, 0);
        req = '0;
        ph  = 0;
        for (int k = 0; k < 200 && busy; k++) begin
            bit_en = (ph == 2);
            ph     = (ph + 1) % 3;
            cyc();
        end
        check("t4_idle",        busy,    0);
        check("t4_valid_cycles", rec_n,  3 * FB);
        check("t4_high_cycles", hi_cnt,  3 * (1 + PAR_BITS));
        check("t4_gap_cycles",  gap_cnt, 1);
        bit_en = 1'b1;

        // 5) Reset at bit 4 of requester 1's frame; requester 3 then gets a
        //    complete fresh frame.
        do_reset();
        set_word(1, 8'hFF);
        set_word(3, 8'hA5);
        req = 4'b1010;
        wait_ack(idx);
        check("t5_first", idx, 1);
        req = 4'b1000;
        for (int k = 0; k < 20 && rec_n < 4; k++) cyc();
        check("t5_reached_bit4", rec_n, 4);
        clear_n = 1'b0;
        #1;
        check("t5_rst_ack",       ack,       0);
        check("t5_rst_busy",      busy,      0);
        check("t5_rst_ser_valid", ser_valid, 0);
        check("t5_rst_ser_out",   ser_out,   0);
        check("t5_rst_grant_id",  grant_id,  0);
        cyc();
        clear_n = 1'b1;
        rec_clear();
        wait_ack(idx);
        check("t5_fresh_id", idx, 3);
        req = '0;
        wait_idle();
        check("t5_fresh_bits", rec_n,        FB);
        check("t5_fresh_word", rec_vec[7:0], 8'hA5);
        set_word(0, 8'h5A);
        req = 4'b0011;
        wait_ack(idx);
        check("t5_after_wrap", idx, 0);
        req = '0;
        wait_idle();

`ifdef SER_TX_PARITY_EN
        // 6) Parity bit: B0 has three ones -> 1; 03 has two ones -> 0.
        do_reset();
        set_word(0, 8'hB0);
        req = 4'b0001;
        wait_ack(idx);
        req = '0;
        wait_idle();
        check("t6_b0_bits",   rec_n,      9);
        check("t6_b0_parity", rec_vec[8], 1);
        rec_clear();
        set_word(0, 8'h03);
        req = 4'b0001;
        wait_ack(idx);
        req = '0;
        wait_idle();
        check("t6_03_word",   rec_vec[7:0], 8'h03);
        check("t6_03_parity", rec_vec[8],   0);
`endif

        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Absolute time bound in case a scenario stalls outside its own budgets.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
